// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing controller.
// Holds the ownership FSM encoding and the idle/blank output patterns.
// Imported by disp_share_ctrl and hex_to_seg.
package disp_pkg;

  // Display ownership: nobody, client 0 or client 1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Active-low patterns: all segments dark, all anodes off
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational, zero latency.
// Standard 0-9 / A-F glyphs (lower-case b and d).
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Font lookup; a lit segment is a 0
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_share_ctrl.sv
// Shares one 4-digit 7-seg display between two requesters with round-robin and a minimum hold.
// Ownership changes only at frame boundaries; an/seg are registered one cycle after idx/state.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 never blanked).
module disp_share_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV_BITS = 17,
  parameter int HOLD_SCANS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int HOLD_W = $clog2(HOLD_SCANS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_SCANS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] cnt;
  logic                     tick;
  logic                     fb;
  logic [IDX_W-1:0]         idx, idx_nxt;
  state_t                   state, state_nxt;
  logic                     rr_ptr, rr_nxt;
  logic [HOLD_W-1:0]        hold_cnt, hold_nxt;
  logic [15:0]              own_data;
  logic [3:0]               nibble;
  logic [6:0]               hex_seg;
  logic                     blank;

  assign tick = &cnt;
  assign fb   = tick && (idx == LAST_IDX);

  // Free-running scan divider; the all-ones value is the one-cycle tick
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  // Ownership FSM next state, digit index, round-robin pointer and hold counter
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    idx_nxt   = tick ? idx + 1'b1 : idx;
    case (state)
      IDLE: begin
        if (tick && (req0 || req1)) begin
          if (req0 && req1) state_nxt = rr_ptr ? OWN1 : OWN0;
          else              state_nxt = req0 ? OWN0 : OWN1;
          // New owner always starts its first frame on digit0
          idx_nxt = '0;
        end
      end
      OWN0: begin
        if (fb) begin
          if (!req0)                             state_nxt = req1 ? OWN1 : IDLE;
          else if (req1 && hold_cnt >= HOLD_MAX) state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (fb) begin
          if (!req1)                             state_nxt = req0 ? OWN0 : IDLE;
          else if (req0 && hold_cnt >= HOLD_MAX) state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      hold_nxt = '0;
      if (state_nxt == OWN0) rr_nxt = 1'b1;
      if (state_nxt == OWN1) rr_nxt = 1'b0;
    end else if (fb && (hold_cnt < HOLD_MAX)) begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  // State registers; grants mirror the registered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      gnt0     <= (state_nxt == OWN0);
      gnt1     <= (state_nxt == OWN1);
    end
  end

  // Owner's digits are taken live, not latched at grant time
  assign own_data = (state == OWN1) ? data1 : data0;
  assign nibble   = own_data[{idx, 2'b00} +: 4];

  hex_to_seg u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank digit k when it and every higher nibble are zero
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (own_data[15:4]  == 12'h000);
      2'd2:    blank = (own_data[15:8]  == 8'h00);
      2'd3:    blank = (own_data[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Registered display drive: one anode per scan slot, dark when unowned
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : hex_seg;
    end
  end

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Self-checking bench for disp_share_ctrl (SCAN_DIV_BITS=2, HOLD_SCANS=2).
// A frame-level reference model tracks owner, scan position and completed frames.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_disp_share_ctrl;

  localparam int SDB    = 2;
  localparam int HS     = 2;
  localparam int PERIOD = 1 << SDB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1;
  logic [3:0]  an;
  logic [6:0]  seg;

  int errors = 0;
  int checks = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  disp_share_ctrl #(.SCAN_DIV_BITS(SDB), .HOLD_SCANS(HS)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cyc = 0, m_pos = 0, m_owner = -1, m_frames = 0, m_rr = 0;
  int         m_next;
  bit         m_tick, m_fb, m_mine, m_other;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_g0 = 1'b0, e_g1 = 1'b0;

  function automatic logic [6:0] exp_digit(input logic [15:0] d, input int p);
    logic [15:0] upper;
    upper = d >> (4 * p);
`ifdef LEADING_ZERO_BLANK_EN
    if (p > 0 && upper == 16'h0) return 7'h7F;
`endif
    return font[upper[3:0]];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_pos = 0; m_owner = -1; m_frames = 0; m_rr = 0;
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      if (m_owner < 0) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an  = 4'hF & ~(4'b0001 << m_pos);
        e_seg = exp_digit((m_owner == 1) ? data1 : data0, m_pos);
      end
      m_tick = (m_cyc % PERIOD) == PERIOD - 1;
      m_cyc++;
      m_fb = m_tick && m_pos == 3;
      m_next = m_owner;
      if (m_owner < 0) begin
        if (m_tick && (req0 || req1)) m_next = (req0 && req1) ? m_rr : (req0 ? 0 : 1);
      end else if (m_fb) begin
        m_mine  = (m_owner == 0) ? req0 : req1;
        m_other = (m_owner == 0) ? req1 : req0;
        if (!m_mine)                     m_next = m_other ? 1 - m_owner : -1;
        else if (m_other && m_frames >= HS) m_next = 1 - m_owner;
      end
      if (m_tick) m_pos = (m_owner < 0 && m_next >= 0) ? 0 : (m_pos + 1) % 4;
      if (m_next != m_owner) begin
        m_frames = 0;
        if (m_next >= 0) m_rr = 1 - m_next;
      end else if (m_fb && m_frames < HS) begin
        m_frames++;
      end
      m_owner = m_next;
    end
    e_g0 = (m_owner == 0);
    e_g1 = (m_owner == 1);
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); end
    checks++; if (dut.idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", dut.idx); end
    checks++; if (dut.cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
    checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL reset_rr: got %b want 0", dut.rr_ptr); end
    checks++; if (dut.hold_cnt !== '0) begin errors++; $display("FAIL reset_hold: got %0d want 0", dut.hold_cnt); end
  endtask

  task automatic test_single_owner();
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    bit got;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    reset = 1'b0; req0 = 1'b1; data0 = 16'h1234;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL single_model: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      got = gnt0;
    end
    checks++; if (!got) begin errors++; $display("FAIL single_grant_timeout: gnt0=%b want 1 within one tick", gnt0); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL single_latency: an=%b want 1111 on grant cycle", an); end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (an !== an_tab[k] || seg !== seg_tab[k]) begin
          errors++;
          $display("FAIL single_digit%0d_clk%0d: an=%b seg=%h want an=%b seg=%h", k, c, an, seg, an_tab[k], seg_tab[k]);
        end
      end
    end
  endtask

  task automatic test_hold_rr();
    int g0cnt;
    int first;
    bit got;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    data0 = 16'($urandom); data1 = 16'($urandom);
    g0cnt = 0; first = -1; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL hold_model: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      if (first < 0 && gnt0) first = 0;
      if (first < 0 && gnt1) first = 1;
      if (gnt0) g0cnt++;
      got = gnt1 && (first == 0);
      if (first == 1) got = 1'b1;
    end
    checks++; if (first !== 0) begin errors++; $display("FAIL hold_first_owner: got %0d want 0", first); end
    checks++; if (!gnt1) begin errors++; $display("FAIL hold_switch_timeout: gnt1=%b want 1", gnt1); end
    checks++; if (g0cnt !== (HS + 1) * 4 * PERIOD) begin errors++; $display("FAIL hold_len: gnt0 held %0d clks want %0d", g0cnt, (HS + 1) * 4 * PERIOD); end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== font[data1[3:0]]) begin
      errors++;
      $display("FAIL hold_new_digit0: an=%b seg=%h want an=1110 seg=%h", an, seg, font[data1[3:0]]);
    end
  endtask

  task automatic test_release();
    bit got;
    int held;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0; req0 = 1'b1; data0 = 16'($urandom);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL release_model: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      got = gnt0;
    end
    checks++; if (!got) begin errors++; $display("FAIL release_grant_timeout: gnt0=%b want 1", gnt0); end
    repeat (6) @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL release_held: gnt0=%b want 1 until frame end", gnt0); end
    held = 0;
    for (int c = 0; c < 20 && gnt0; c++) begin
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL release_model2: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      held++;
      @(negedge clk);
    end
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL release_idle: gnt=%b%b want 00", gnt0, gnt1); end
    checks++; if (held > 4 * PERIOD) begin errors++; $display("FAIL release_late: held %0d clks want <= %0d", held, 4 * PERIOD); end
    @(negedge clk);
    checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin errors++; $display("FAIL release_blank: an=%b seg=%h want 1111 7f", an, seg); end
  endtask

  task automatic test_reset_mid();
    bit got;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0; req1 = 1'b1; data1 = 16'($urandom);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL midrst_model: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      got = gnt1 && (dut.idx == 2'd2);
    end
    checks++; if (!got) begin errors++; $display("FAIL midrst_timeout: gnt1=%b idx=%0d want OWN1 at idx 2", gnt1, dut.idx); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL midrst_gnt: gnt=%b%b want 00", gnt0, gnt1); end
    checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin errors++; $display("FAIL midrst_out: an=%b seg=%h want 1111 7f", an, seg); end
    checks++; if (dut.idx !== 2'd0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", dut.idx); end
    checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL midrst_rr: got %b want 0", dut.rr_ptr); end
    reset = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL random_model cyc%0d: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", c, an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      if ($urandom_range(0, 23) == 0) req0 = ~req0;
      if ($urandom_range(0, 23) == 0) req1 = ~req1;
      if ($urandom_range(0, 9) == 0) data0 = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) data1 = 16'($urandom) >> $urandom_range(0, 15);
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
  endtask

  task automatic test_blank();
    logic [6:0] want;
    int seen;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0; req0 = 1'b1; data0 = 16'h0050;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, gnt0, gnt1} !== {e_an, e_seg, e_g0, e_g1}) begin
        errors++;
        $display("FAIL blank_model: an=%b seg=%h gnt=%b%b want an=%b seg=%h gnt=%b%b", an, seg, gnt0, gnt1, e_an, e_seg, e_g0, e_g1);
      end
      if (an != 4'b1111) begin
        seen++;
        case (an)
          4'b1110: want = 7'h40;
          4'b1101: want = 7'h12;
`ifdef LEADING_ZERO_BLANK_EN
          default: want = 7'h7F;
`else
          default: want = 7'h40;
`endif
        endcase
        checks++;
        if (seg !== want) begin errors++; $display("FAIL blank_digit an=%b: seg=%h want %h", an, seg, want); end
      end
    end
    checks++; if (seen < 16) begin errors++; $display("FAIL blank_coverage: %0d lit slots want >= 16", seen); end
    req0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_hold_rr();
    test_release();
    test_reset_mid();
    test_random();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
